// File: rtl/otp_backdoor_pkg.sv
// Shared types for the OTP emulation backing store.
// Host command codes, FSM state encoding and an address-width helper.
package otp_backdoor_pkg;

  typedef enum logic [1:0] {
    CmdRead  = 2'd0,
    CmdWrite = 2'd1,
    CmdClear = 2'd2,
    CmdRsvd  = 2'd3
  } host_cmd_e;

  // Codes sit at least three bit flips apart
  typedef enum logic [4:0] {
    IdleSt  = 5'b00000,
    ClearSt = 5'b00111,
    ErrorSt = 5'b11001
  } state_e;

  function automatic int vbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/otp_backdoor_ram.sv
// Single-port synchronous-read RAM for block RAM inference.
// Read data only updates on a read access and holds otherwise.
module otp_backdoor_ram #(
  parameter int Width     = 16,
  parameter int Depth     = 1024,
  parameter int AddrWidth = 10
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [Width-1:0]     wdata_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/otp_backdoor_mem.sv
// OTP macro backing store with a lower-priority host backdoor.
// OTP accesses always win the single RAM port; host traffic waits.
module otp_backdoor_mem
  import otp_backdoor_pkg::*;
#(
  parameter int  Width     = 16,
  parameter int  Depth     = 1024,
  parameter int  CntWidth  = 32,
  localparam int AddrWidth = vbits(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 otp_en_i,
  input  logic                 otp_we_i,
  input  logic [AddrWidth-1:0] otp_addr_i,
  input  logic [Width-1:0]     otp_wdata_i,
  output logic [Width-1:0]     otp_rdata_o,
  input  logic                 host_valid_i,
  output logic                 host_ready_o,
  input  logic [1:0]           host_cmd_i,
  input  logic [AddrWidth-1:0] host_addr_i,
  input  logic [Width-1:0]     host_wdata_i,
  output logic                 host_rvalid_o,
  output logic [Width-1:0]     host_rdata_o,
  output logic                 host_err_o,
  input  logic                 lock_i,
  output logic                 busy_o,
  output logic [CntWidth-1:0]  otp_wr_cnt_o
);

  localparam logic [AddrWidth:0] DepthW =
    (AddrWidth+1)'(Depth);
  localparam logic [AddrWidth-1:0] LastAddr =
    AddrWidth'(Depth - 1);

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] clr_q, clr_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 otp_rd_q, otp_rd_d;
  logic                 host_rd_q, host_rd_d;
  logic [Width-1:0]     otp_hold_q, otp_hold_d;
  logic [Width-1:0]     host_hold_q, host_hold_d;
  logic                 rvalid_q, rvalid_d;
  logic                 err_q, err_d;

  logic                 ram_en, ram_we;
  logic [AddrWidth-1:0] ram_addr;
  logic [Width-1:0]     ram_wdata, ram_rdata;
  host_cmd_e            cmd;
  logic                 in_range;
  logic                 host_rd, host_wr, clr_wr;

  assign cmd      = host_cmd_e'(host_cmd_i);
  assign in_range = {1'b0, host_addr_i} < DepthW;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IdleSt;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      IdleSt: begin
        if (host_valid_i && !otp_en_i &&
            cmd == CmdClear && !lock_i) begin
          state_d = ClearSt;
          clr_d   = '0;
        end
      end
      ClearSt: begin
        if (clr_wr) begin
          clr_d = clr_q + 1'b1;
          if (clr_q == LastAddr) state_d = IdleSt;
        end
      end
      default: state_d = ErrorSt;
    endcase
  end

  always_comb begin
    host_ready_o = 1'b0;
    host_rd      = 1'b0;
    host_wr      = 1'b0;
    clr_wr       = 1'b0;
    rvalid_d     = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IdleSt: begin
        host_ready_o = !otp_en_i;
        if (host_valid_i && !otp_en_i) begin
          rvalid_d = 1'b1;
          unique case (cmd)
            CmdRead: begin
              host_rd = in_range;
              err_d   = !in_range;
            end
            CmdWrite: begin
              host_wr = in_range && !lock_i;
              err_d   = !in_range || lock_i;
            end
            // An unlocked Clear answers when the sweep ends
            CmdClear: begin
              rvalid_d = lock_i;
              err_d    = lock_i;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ClearSt: begin
        clr_wr   = !otp_en_i && !rst_i;
        rvalid_d = clr_wr && (clr_q == LastAddr);
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_en    = otp_en_i || host_rd || host_wr || clr_wr;
    ram_we    = otp_en_i ? otp_we_i : (host_wr || clr_wr);
    ram_addr  = otp_en_i ? otp_addr_i :
                (clr_wr ? clr_q : host_addr_i);
    ram_wdata = otp_en_i ? otp_wdata_i :
                (clr_wr ? '0 : host_wdata_i);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (otp_en_i && otp_we_i && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
    otp_rd_d    = otp_en_i && !otp_we_i;
    host_rd_d   = host_rd;
    otp_hold_d  = otp_rd_q ? ram_rdata : otp_hold_q;
    host_hold_d = host_rd_q ? ram_rdata : host_hold_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clr_q       <= '0;
      cnt_q       <= '0;
      otp_rd_q    <= 1'b0;
      host_rd_q   <= 1'b0;
      otp_hold_q  <= '0;
      host_hold_q <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clr_q       <= clr_d;
      cnt_q       <= cnt_d;
      otp_rd_q    <= otp_rd_d;
      host_rd_q   <= host_rd_d;
      otp_hold_q  <= otp_hold_d;
      host_hold_q <= host_hold_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  otp_backdoor_ram #(
    .Width    (Width),
    .Depth    (Depth),
    .AddrWidth(AddrWidth)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign otp_rdata_o   = otp_rd_q ? ram_rdata : otp_hold_q;
  assign host_rdata_o  = host_rd_q ? ram_rdata : host_hold_q;
  assign host_rvalid_o = rvalid_q;
  assign host_err_o    = err_q;
  assign busy_o        = (state_q == ClearSt);
  assign otp_wr_cnt_o  = cnt_q;

endmodule

// File: tb/tb_otp_backdoor_mem.sv
// Self-checking bench for otp_backdoor_mem.
// Array-based reference memory with a saturating write count.
module tb_otp_backdoor_mem;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        otp_en_i, otp_we_i;
  logic [9:0]  otp_addr_i;
  logic [15:0] otp_wdata_i, otp_rdata_o;
  logic        host_valid_i, host_ready_o;
  logic [1:0]  host_cmd_i;
  logic [9:0]  host_addr_i;
  logic [15:0] host_wdata_i, host_rdata_o;
  logic        host_rvalid_o, host_err_o;
  logic        lock_i, busy_o;
  logic [3:0]  otp_wr_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] mem_m [1024];
  logic [3:0]  cnt_m;

  always #5 clk = ~clk;

  otp_backdoor_mem #(
    .Width(16), .Depth(1024), .CntWidth(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .otp_en_i(otp_en_i), .otp_we_i(otp_we_i),
    .otp_addr_i(otp_addr_i), .otp_wdata_i(otp_wdata_i),
    .otp_rdata_o(otp_rdata_o),
    .host_valid_i(host_valid_i), .host_ready_o(host_ready_o),
    .host_cmd_i(host_cmd_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_rvalid_o(host_rvalid_o),
    .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .lock_i(lock_i), .busy_o(busy_o), .otp_wr_cnt_o(otp_wr_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; otp_en_i = 1'b0; otp_we_i = 1'b0;
    otp_addr_i = '0; otp_wdata_i = '0;
    host_valid_i = 1'b0; host_cmd_i = '0;
    host_addr_i = '0; host_wdata_i = '0; lock_i = 1'b0;
    tick(); tick();
    rst_i = 1'b0;
    cnt_m = '0;
  endtask

  task automatic host_op(input logic [1:0] c, input logic [9:0] a,
                         input logic [15:0] d, output logic rv,
                         output logic [15:0] rd, output logic er);
    int n;
    host_valid_i = 1'b1; host_cmd_i = c;
    host_addr_i = a; host_wdata_i = d;
    #1;
    n = 0;
    while (!host_ready_o && n < 100) begin
      tick(); #1; n++;
    end
    tick();
    host_valid_i = 1'b0;
    rv = host_rvalid_o; rd = host_rdata_o; er = host_err_o;
  endtask

  task automatic otp_op(input logic we, input logic [9:0] a,
                        input logic [15:0] d);
    otp_en_i = 1'b1; otp_we_i = we; otp_addr_i = a; otp_wdata_i = d;
    tick();
    otp_en_i = 1'b0; otp_we_i = 1'b0;
    if (we) begin
      mem_m[a] = d;
      if (cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
    end
  endtask

  task automatic test_reset();
    total += 7;
    if (otp_rdata_o !== 16'h0) begin bad++; $display("FAIL rst_otp_rdata got=%h want=0", otp_rdata_o); end
    if (host_rdata_o !== 16'h0) begin bad++; $display("FAIL rst_host_rdata got=%h want=0", host_rdata_o); end
    if (host_rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", host_rvalid_o); end
    if (host_err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", host_err_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
    if (otp_wr_cnt_o !== 4'h0) begin bad++; $display("FAIL rst_cnt got=%h want=0", otp_wr_cnt_o); end
    if (host_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", host_ready_o); end
  endtask

  task automatic test_write_otp_read();
    logic rv, er; logic [15:0] rd;
    host_op(2'd1, 10'h010, 16'hA5A5, rv, rd, er);
    mem_m[16] = 16'hA5A5;
    total += 2;
    if (rv !== 1'b1) begin bad++; $display("FAIL wr_rvalid got=%b want=1", rv); end
    if (er !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", er); end
    tick();
    total++;
    if (host_rvalid_o !== 1'b0) begin bad++; $display("FAIL wr_pulse got=%b want=0", host_rvalid_o); end
    otp_op(1'b0, 10'h010, 16'h0);
    total++;
    if (otp_rdata_o !== 16'hA5A5) begin bad++; $display("FAIL otp_rd got=%h want=a5a5", otp_rdata_o); end
    host_op(2'd1, 10'h011, 16'h1111, rv, rd, er);
    mem_m[17] = 16'h1111;
    host_op(2'd0, 10'h011, 16'h0, rv, rd, er);
    total += 2;
    if (rd !== 16'h1111) begin bad++; $display("FAIL host_rd got=%h want=1111", rd); end
    if (otp_rdata_o !== 16'hA5A5) begin bad++; $display("FAIL otp_hold got=%h want=a5a5", otp_rdata_o); end
  endtask

  task automatic test_contention();
    otp_en_i = 1'b1; otp_we_i = 1'b1;
    otp_addr_i = 10'h020; otp_wdata_i = 16'h00F0;
    host_valid_i = 1'b1; host_cmd_i = 2'd0; host_addr_i = 10'h020;
    #1;
    total++;
    if (host_ready_o !== 1'b0) begin bad++; $display("FAIL cont_ready got=%b want=0", host_ready_o); end
    tick();
    otp_en_i = 1'b0; otp_we_i = 1'b0;
    mem_m[32] = 16'h00F0;
    if (cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
    #1;
    total++;
    if (host_ready_o !== 1'b1) begin bad++; $display("FAIL cont_ready2 got=%b want=1", host_ready_o); end
    tick();
    host_valid_i = 1'b0;
    total += 3;
    if (host_rvalid_o !== 1'b1) begin bad++; $display("FAIL cont_rvalid got=%b want=1", host_rvalid_o); end
    if (host_rdata_o !== 16'h00F0) begin bad++; $display("FAIL cont_rdata got=%h want=00f0", host_rdata_o); end
    if (otp_wr_cnt_o !== cnt_m) begin bad++; $display("FAIL cont_cnt got=%h want=%h", otp_wr_cnt_o, cnt_m); end
  endtask

  task automatic test_lock();
    logic rv, er; logic [15:0] rd;
    host_op(2'd1, 10'h030, 16'h5555, rv, rd, er);
    mem_m[48] = 16'h5555;
    lock_i = 1'b1;
    host_op(2'd1, 10'h030, 16'hFFFF, rv, rd, er);
    total += 2;
    if (rv !== 1'b1) begin bad++; $display("FAIL lock_wr_rv got=%b want=1", rv); end
    if (er !== 1'b1) begin bad++; $display("FAIL lock_wr_err got=%b want=1", er); end
    host_op(2'd2, 10'h000, 16'h0, rv, rd, er);
    total += 2;
    if (er !== 1'b1) begin bad++; $display("FAIL lock_clr_err got=%b want=1", er); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL lock_clr_busy got=%b want=0", busy_o); end
    lock_i = 1'b0;
    host_op(2'd0, 10'h030, 16'h0, rv, rd, er);
    total++;
    if (rd !== 16'h5555) begin bad++; $display("FAIL lock_keep got=%h want=5555", rd); end
  endtask

  task automatic test_reserved();
    logic rv, er; logic [15:0] rd;
    host_op(2'd3, 10'h040, 16'h0, rv, rd, er);
    total += 2;
    if (rv !== 1'b1) begin bad++; $display("FAIL rsvd_rv got=%b want=1", rv); end
    if (er !== 1'b1) begin bad++; $display("FAIL rsvd_err got=%b want=1", er); end
  endtask

  task automatic test_back_to_back_fill(input logic [15:0] v);
    int pulses = 0;
    host_valid_i = 1'b1; host_cmd_i = 2'd1; host_wdata_i = v;
    for (int i = 0; i < 1024; i++) begin
      host_addr_i = 10'(i);
      mem_m[i] = v;
      tick();
      if (host_rvalid_o === 1'b1) pulses++;
    end
    host_valid_i = 1'b0;
    tick();
    if (host_rvalid_o === 1'b1) pulses++;
    total++;
    if (pulses != 1024) begin bad++; $display("FAIL fill_pulses got=%0d want=1024", pulses); end
  endtask

  task automatic test_readback(input string tag);
    host_valid_i = 1'b1; host_cmd_i = 2'd0;
    for (int i = 0; i < 1024; i++) begin
      host_addr_i = 10'(i);
      tick();
      total++;
      if (host_rvalid_o !== 1'b1 || host_rdata_o !== mem_m[i]) begin
        bad++;
        $display("FAIL %s a=%0d got=%h rv=%b want=%h", tag, i, host_rdata_o, host_rvalid_o, mem_m[i]);
      end
    end
    host_valid_i = 1'b0;
    tick();
  endtask

  task automatic start_clear();
    host_valid_i = 1'b1; host_cmd_i = 2'd2; host_addr_i = 10'h155;
    tick();
    host_valid_i = 1'b0;
  endtask

  task automatic test_clear_inject();
    int busy_cyc = 0, stalls = 0, p = 0;
    bit pend = 0, done = 0;
    logic [9:0] a;
    logic [15:0] pexp;
    start_clear();
    for (int i = 0; i < 3000 && !done; i++) begin
      if (pend) begin
        total++;
        if (otp_rdata_o !== pexp) begin bad++; $display("FAIL clr_otp_rd got=%h want=%h", otp_rdata_o, pexp); end
        pend = 0;
      end
      if (host_rvalid_o === 1'b1) begin
        done = 1;
        total += 2;
        if (host_err_o !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", host_err_o); end
        if (busy_o !== 1'b0) begin bad++; $display("FAIL clr_busy_end got=%b want=0", busy_o); end
      end else if (busy_o === 1'b1) begin
        busy_cyc++;
        if (i % 4 == 3) begin
          a = 10'($urandom_range(0, 1023));
          otp_en_i = 1'b1; otp_we_i = 1'b0; otp_addr_i = a;
          pexp = (int'(a) < p) ? 16'h0 : mem_m[a];
          pend = 1; stalls++;
        end else p++;
      end
      tick();
      otp_en_i = 1'b0;
    end
    for (int i = 0; i < 1024; i++) mem_m[i] = 16'h0;
    total += 3;
    if (!done) begin bad++; $display("FAIL clr_timeout got=no_rvalid want=rvalid"); end
    if (busy_cyc != 1024 + stalls) begin bad++; $display("FAIL clr_busy_len got=%0d want=%0d", busy_cyc, 1024 + stalls); end
    if (host_rvalid_o !== 1'b0) begin bad++; $display("FAIL clr_pulse got=%b want=0", host_rvalid_o); end
  endtask

  task automatic test_random();
    logic hv = 1'b0, otp_known = 1'b0;
    logic [1:0] hc; logic [9:0] ha; logic [15:0] hd;
    logic e_rv, e_err, e_rdc; logic [15:0] e_rd, e_otp;
    logic oe, ow, lk; logic [9:0] oa; logic [15:0] od;
    int r;
    e_rd = '0; e_otp = '0; e_err = 1'b0;
    hc = '0; ha = '0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      oe = ($urandom_range(0, 2) == 0);
      ow = ($urandom_range(0, 1) == 1);
      oa = 10'($urandom_range(0, 15));
      od = 16'($urandom);
      lk = ($urandom_range(0, 4) == 0);
      if (!hv && $urandom_range(0, 1) == 1) begin
        hv = 1'b1;
        r = int'($urandom_range(0, 8));
        hc = (r < 4) ? 2'd0 : ((r < 8) ? 2'd1 : 2'd3);
        ha = 10'($urandom_range(0, 15));
        hd = 16'($urandom);
      end
      otp_en_i = oe; otp_we_i = ow; otp_addr_i = oa; otp_wdata_i = od;
      lock_i = lk; host_valid_i = hv; host_cmd_i = hc;
      host_addr_i = ha; host_wdata_i = hd;
      #1;
      total++;
      if (host_ready_o !== !oe) begin bad++; $display("FAIL rnd_ready got=%b want=%b", host_ready_o, !oe); end
      e_rv = 1'b0; e_rdc = 1'b0;
      if (oe) begin
        if (ow) begin
          mem_m[oa] = od;
          if (cnt_m != 4'hF) cnt_m = cnt_m + 4'd1;
        end else begin
          e_otp = mem_m[oa]; otp_known = 1'b1;
        end
      end else if (hv) begin
        e_rv = 1'b1; hv = 1'b0;
        if (hc == 2'd0) begin
          e_rd = mem_m[ha]; e_rdc = 1'b1; e_err = 1'b0;
        end else if (hc == 2'd1) begin
          e_err = lk;
          if (!lk) mem_m[ha] = hd;
        end else e_err = 1'b1;
      end
      tick();
      total += 2;
      if (host_rvalid_o !== e_rv) begin bad++; $display("FAIL rnd_rvalid got=%b want=%b", host_rvalid_o, e_rv); end
      if (otp_wr_cnt_o !== cnt_m) begin bad++; $display("FAIL rnd_cnt got=%h want=%h", otp_wr_cnt_o, cnt_m); end
      if (e_rv) begin
        total++;
        if (host_err_o !== e_err) begin bad++; $display("FAIL rnd_err got=%b want=%b", host_err_o, e_err); end
      end
      if (e_rdc) begin
        total++;
        if (host_rdata_o !== e_rd) begin bad++; $display("FAIL rnd_hrd got=%h want=%h", host_rdata_o, e_rd); end
      end
      if (otp_known) begin
        total++;
        if (otp_rdata_o !== e_otp) begin bad++; $display("FAIL rnd_otp got=%h want=%h", otp_rdata_o, e_otp); end
      end
    end
    otp_en_i = 1'b0; otp_we_i = 1'b0; host_valid_i = 1'b0; lock_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int p = 0;
    test_back_to_back_fill(16'h1234);
    start_clear();
    for (int i = 0; i < 2000 && p < 512; i++) begin
      if (busy_o === 1'b1) p++;
      tick();
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cnt_m = '0;
    for (int i = 0; i < 512; i++) mem_m[i] = 16'h0;
    total += 3;
    if (p != 512) begin bad++; $display("FAIL mid_reach got=%0d want=512", p); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy_o); end
    if (host_rvalid_o !== 1'b0) begin bad++; $display("FAIL mid_rvalid got=%b want=0", host_rvalid_o); end
    tick();
    total++;
    if (host_rvalid_o !== 1'b0) begin bad++; $display("FAIL mid_rvalid2 got=%b want=0", host_rvalid_o); end
    test_readback("mid_rd");
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 17; k++) begin
      otp_op(1'b1, 10'h3F0 + 10'(k % 8), 16'($urandom));
      total++;
      if (otp_wr_cnt_o !== cnt_m) begin bad++; $display("FAIL sat_cnt k=%0d got=%h want=%h", k, otp_wr_cnt_o, cnt_m); end
    end
    total++;
    if (otp_wr_cnt_o !== 4'hF) begin bad++; $display("FAIL sat_final got=%h want=f", otp_wr_cnt_o); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_write_otp_read();
    test_contention();
    test_lock();
    test_reserved();
    test_back_to_back_fill(16'h1234);
    test_readback("fill_rd");
    test_clear_inject();
    test_readback("clr_rd");
    test_random();
    test_reset_mid_clear();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
